// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch stage in front of the multi-cycle control FSM. It issues word reads to
//   instruction memory over a req/ack handshake and holds at most one
//   prefetched instruction. The control FSM sees W_IR_valid and loads IR/PC
//   with write_ir. A redirect (pc_load) retargets fetching. If a request is
//   already outstanding, the redirect waits for that ack and throws its data
//   away. A sticky timeout flag reports a memory that never answers.
//
// Ports
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   write_pc      from control FSM, only meaningful together with write_ir
//   write_ir      consume the buffered instruction into IR/PC
//   pc_load       single-cycle redirect strobe
//   pc_new        redirect target (low two bits ignored)
//   imem_req      fetch request level, imem_addr stable while high
//   imem_addr     fetch word address
//   imem_ack      one-cycle response strobe, meaningful only while imem_req=1
//   imem_rdata    instruction word qualified by imem_ack
//   W_IR_valid    buffer holds an instruction ready for IR
//   IR            instruction register
//   PC            address of the instruction in IR, plus 4
//   fetch_err     sticky timeout flag, cleared by rst or pc_load
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 TO_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_pc,
  input  logic              write_ir,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_new,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              W_IR_valid,
  output logic [DATA_W-1:0] IR,
  output logic [ADDR_W-1:0] PC,
  output logic              fetch_err
);

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_REQ  = 2'd1,
    F_FULL = 2'd2,
    F_DROP = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);
  localparam logic [TO_W-1:0]   TO_MAX    = '1;
  localparam logic [TO_W-1:0]   TO_LAST   = TO_MAX - 1'b1;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

  // Saturating increment keeps the stall counter parked at all-ones.
  function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] c);
    return (c == TO_MAX) ? c : c + 1'b1;
  endfunction

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   fetch_addr;
  logic [ADDR_W-1:0]   fetch_addr_next;
  logic [DATA_W-1:0]   buf_data;
  logic [ADDR_W-1:0]   buf_addr;
  logic                buf_valid;
  logic [TO_W-1:0]     to_cnt;

  logic                in_req;
  logic                buf_load;
  logic                buf_clr;
  logic                ir_load;
  logic                addr_inc;
  logic                addr_tgt;
  logic                tgt_save;
  logic [ADDR_W-1:0]   redirect_addr;

  // write_pc carries no information beyond write_ir here.
  logic                unused_ok;
  assign unused_ok = write_pc;

  assign in_req     = (state == F_REQ) || (state == F_DROP);
  assign imem_req   = in_req;
  assign imem_addr  = fetch_addr;
  assign W_IR_valid = buf_valid;

  // A redirect in the same cycle as a dropped ack wins over the pending target.
  assign redirect_addr = pc_load ? word_align(pc_new) : fetch_addr_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= F_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    buf_load  = 1'b0;
    buf_clr   = 1'b0;
    ir_load   = 1'b0;
    addr_inc  = 1'b0;
    addr_tgt  = 1'b0;
    tgt_save  = 1'b0;
    case (state)
      F_IDLE: begin
        state_nxt = F_REQ;
        addr_tgt  = pc_load;
      end
      F_REQ: begin
        if (pc_load) begin
          if (imem_ack) begin
            addr_tgt  = 1'b1;
          end else begin
            // Request is outstanding: keep imem_addr stable and wait it out.
            tgt_save  = 1'b1;
            state_nxt = F_DROP;
          end
        end else if (imem_ack) begin
          buf_load  = 1'b1;
          addr_inc  = 1'b1;
          state_nxt = F_FULL;
        end
      end
      F_FULL: begin
        if (pc_load) begin
          addr_tgt  = 1'b1;
          buf_clr   = 1'b1;
          state_nxt = F_REQ;
        end else if (write_ir) begin
          ir_load   = 1'b1;
          buf_clr   = 1'b1;
          state_nxt = F_REQ;
        end
      end
      F_DROP: begin
        if (imem_ack) begin
          addr_tgt  = 1'b1;
          state_nxt = F_REQ;
        end else if (pc_load) begin
          tgt_save  = 1'b1;
        end
      end
      default: state_nxt = F_IDLE;
    endcase
  end

  // Control and architecturally visible registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_addr <= RESET_PC;
      buf_valid  <= 1'b0;
      IR         <= '0;
      PC         <= RESET_PC;
      to_cnt     <= '0;
      fetch_err  <= 1'b0;
    end else begin
      if (addr_tgt)      fetch_addr <= redirect_addr;
      else if (addr_inc) fetch_addr <= fetch_addr + WORD_STEP;

      if (buf_load)      buf_valid <= 1'b1;
      else if (buf_clr)  buf_valid <= 1'b0;

      if (ir_load) begin
        IR <= buf_data;
        PC <= buf_addr + WORD_STEP;
      end

      if (in_req && !imem_ack) to_cnt <= sat_inc(to_cnt);
      else                     to_cnt <= '0;

      if (pc_load)                                         fetch_err <= 1'b0;
      else if (in_req && !imem_ack && (to_cnt == TO_LAST)) fetch_err <= 1'b1;
    end
  end

  // Payload registers; their contents only matter while qualified by state.
  always_ff @(posedge clk) begin
    if (buf_load) begin
      buf_data <= imem_rdata;
      buf_addr <= fetch_addr;
    end
    if (tgt_save) fetch_addr_next <= word_align(pc_new);
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        write_pc = 1'b0, write_ir = 1'b0, pc_load = 1'b0;
  logic [31:0] pc_new = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        W_IR_valid;
  logic [31:0] IR, PC;
  logic        fetch_err;

  logic        write_pc2 = 1'b0, write_ir2 = 1'b0, pc_load2 = 1'b0;
  logic [31:0] pc_new2 = '0;
  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic        imem_ack2 = 1'b0;
  logic [31:0] imem_rdata2 = '0;
  logic        W_IR_valid2;
  logic [31:0] IR2, PC2;
  logic        fetch_err2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0000_0000), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .write_pc(write_pc), .write_ir(write_ir),
    .pc_load(pc_load), .pc_new(pc_new), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .W_IR_valid(W_IR_valid),
    .IR(IR), .PC(PC), .fetch_err(fetch_err)
  );

  instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'hFFFF_FFFC), .TO_W(8)) dut2 (
    .clk(clk), .rst(rst), .write_pc(write_pc2), .write_ir(write_ir2),
    .pc_load(pc_load2), .pc_new(pc_new2), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack2), .imem_rdata(imem_rdata2), .W_IR_valid(W_IR_valid2),
    .IR(IR2), .PC(PC2), .fetch_err(fetch_err2)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    check_eq("rst_pc", PC, 32'h0);
    check_eq("rst_addr", imem_addr, 32'h0);
    check_eq("rst_ir", IR, 32'h0);
    check_eq("rst_valid", W_IR_valid, 1'b0);
    check_eq("rst_req", imem_req, 1'b0);
    check_eq("rst_err", fetch_err, 1'b0);

    // Release; F_IDLE lasts one cycle, then request at RESET_PC
    rst = 1'b0;
    #1 check_eq("idle_req", imem_req, 1'b0);
    tick();
    check_eq("req_high", imem_req, 1'b1);
    check_eq("req_addr0", imem_addr, 32'h0);
    check_eq("req_novalid", W_IR_valid, 1'b0);
    imem_ack = 1'b1; imem_rdata = 32'hE081_0002;
    tick();
    imem_ack = 1'b0;
    check_eq("fill_valid", W_IR_valid, 1'b1);
    check_eq("fill_req_low", imem_req, 1'b0);
    check_eq("fill_ir_hold", IR, 32'h0);
    write_ir = 1'b1;
    tick();
    write_ir = 1'b0;
    check_eq("ld_ir", IR, 32'hE081_0002);
    check_eq("ld_pc", PC, 32'h4);
    check_eq("ld_valid_clr", W_IR_valid, 1'b0);
    check_eq("next_req", imem_req, 1'b1);
    check_eq("next_addr", imem_addr, 32'h4);

    // write_pc alone does nothing
    imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
    tick();
    imem_ack = 1'b0;
    write_pc = 1'b1;
    repeat (5) tick();
    write_pc = 1'b0;
    check_eq("wpc_ir", IR, 32'hE081_0002);
    check_eq("wpc_pc", PC, 32'h4);
    check_eq("wpc_valid", W_IR_valid, 1'b1);
    check_eq("wpc_req", imem_req, 1'b0);
    check_eq("wpc_addr", imem_addr, 32'h8);
    write_ir = 1'b1;
    tick();
    write_ir = 1'b0;
    check_eq("ld2_ir", IR, 32'h1111_1111);
    check_eq("ld2_pc", PC, 32'h8);
    check_eq("ld2_addr", imem_addr, 32'h8);

    // Redirect while a request is outstanding
    pc_load = 1'b1; pc_new = 32'h0000_0103;
    tick();
    pc_load = 1'b0;
    check_eq("drop_req", imem_req, 1'b1);
    check_eq("drop_addr_a", imem_addr, 32'h8);
    tick();
    check_eq("drop_addr_b", imem_addr, 32'h8);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    check_eq("drop_discard", W_IR_valid, 1'b0);
    check_eq("redir_req", imem_req, 1'b1);
    check_eq("redir_addr", imem_addr, 32'h100);
    imem_ack = 1'b1; imem_rdata = 32'h2222_0100;
    tick();
    imem_ack = 1'b0;
    check_eq("redir_valid", W_IR_valid, 1'b1);
    write_ir = 1'b1;
    tick();
    write_ir = 1'b0;
    check_eq("redir_ir", IR, 32'h2222_0100);
    check_eq("redir_pc", PC, 32'h104);

    // Redirect coincident with write_ir in F_FULL
    imem_ack = 1'b1; imem_rdata = 32'h3333_3333;
    tick();
    imem_ack = 1'b0;
    write_ir = 1'b1; pc_load = 1'b1; pc_new = 32'h0000_0200;
    tick();
    write_ir = 1'b0; pc_load = 1'b0;
    check_eq("coin_ir", IR, 32'h2222_0100);
    check_eq("coin_pc", PC, 32'h104);
    check_eq("coin_valid", W_IR_valid, 1'b0);
    check_eq("coin_req", imem_req, 1'b1);
    check_eq("coin_addr", imem_addr, 32'h200);

    // Timeout: entered F_REQ at the last edge
    repeat (254) tick();
    check_eq("to_254", fetch_err, 1'b0);
    tick();
    check_eq("to_255", fetch_err, 1'b1);
    repeat (3) tick();
    check_eq("to_sticky", fetch_err, 1'b1);
    check_eq("to_still_req", imem_req, 1'b1);
    imem_ack = 1'b1; imem_rdata = 32'h4444_4444;
    tick();
    imem_ack = 1'b0;
    check_eq("to_late_fill", W_IR_valid, 1'b1);
    check_eq("to_err_kept", fetch_err, 1'b1);
    pc_load = 1'b1; pc_new = 32'h0000_0300;
    tick();
    pc_load = 1'b0;
    check_eq("to_err_clr", fetch_err, 1'b0);
    check_eq("to_redir_valid", W_IR_valid, 1'b0);
    check_eq("to_redir_addr", imem_addr, 32'h300);

    // Async reset in the middle of a request
    check_eq("pre_rst_req", imem_req, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("arst_req", imem_req, 1'b0);
    check_eq("arst_addr", imem_addr, 32'h0);
    tick();
    rst = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
    tick();
    imem_ack = 1'b0;
    check_eq("late_ack_ignored", W_IR_valid, 1'b0);
    check_eq("post_rst_req", imem_req, 1'b1);
    check_eq("post_rst_addr", imem_addr, 32'h0);

    // Second instance: address wrap from 0xFFFF_FFFC
    check_eq("wrap_req", imem_req2, 1'b1);
    check_eq("wrap_addr0", imem_addr2, 32'hFFFF_FFFC);
    imem_ack2 = 1'b1; imem_rdata2 = 32'hAAAA_5555;
    tick();
    imem_ack2 = 1'b0;
    write_ir2 = 1'b1;
    tick();
    write_ir2 = 1'b0;
    check_eq("wrap_ir", IR2, 32'hAAAA_5555);
    check_eq("wrap_pc", PC2, 32'h0);
    check_eq("wrap_next_addr", imem_addr2, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the multi-cycle control FSM.
- Issues word requests to instruction memory over a req/ack handshake and holds one prefetched instruction in a buffer.
- Presents `W_IR_valid` to the control FSM and loads `IR`/`PC` when the FSM asserts `write_ir`.
- Supports a PC redirect for branches, with safe discard of an in-flight fetch, and a fetch-timeout error flag.

Parameters:
- ADDR_W, 32, width of PC and instruction-memory address.
- DATA_W, 32, instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be word aligned.
- TO_W, 8, timeout counter width; timeout fires after 2^TO_W-1 cycles without ack.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- write_pc  input  1  from control FSM; qualified by write_ir, ignored alone.
- write_ir  input  1  from control FSM; consume buffered instruction.
- pc_load  input  1  redirect strobe, single cycle.
- pc_new  input  ADDR_W  redirect target; bits [1:0] forced to 0.
- imem_req  output  1  fetch request, level.
- imem_addr  output  ADDR_W  fetch address, stable while imem_req=1.
- imem_ack  input  1  one-cycle response strobe; valid only while imem_req=1.
- imem_rdata  input  DATA_W  instruction word, valid with imem_ack.
- W_IR_valid  output  1  buffer holds an instruction ready for IR.
- IR  output  DATA_W  instruction register.
- PC  output  ADDR_W  address of instruction in IR + 4.
- fetch_err  output  1  sticky timeout flag.

Behaviour:
- Reset (async, immediate):
  - PC=RESET_PC, imem_addr=RESET_PC, IR=0.
  - W_IR_valid=0, imem_req=0, fetch_err=0.
  - buffer empty, timeout counter 0, state F_IDLE.
- All outputs are registered. imem_req is decoded from state: 1 in F_REQ and F_DROP.
- Internal registers:
  - fetch_addr (drives imem_addr).
  - buf_data, buf_addr, buf_valid (drives W_IR_valid).
  - to_cnt.
- F_IDLE: unconditionally -> F_REQ next cycle. imem_req first high in cycle 2 after reset release.
- F_REQ:
  - On imem_ack: buf_data<=imem_rdata, buf_addr<=fetch_addr, buf_valid<=1, fetch_addr<=fetch_addr+4, -> F_FULL.
  - W_IR_valid rises the cycle after ack (1-cycle latency).
- F_FULL:
  - On write_ir=1: IR<=buf_data, PC<=buf_addr+4, buf_valid<=0, -> F_REQ.
  - write_pc is accepted but changes nothing beyond the above.
- write_ir while buf_valid=0: ignored, no IR/PC change.
- Consume and next request are not overlapped: one instruction buffered at most.
- pc_load in F_FULL or F_IDLE: fetch_addr<=pc_new&~3, buf_valid<=0, -> F_REQ. A same-cycle write_ir is ignored; IR and PC are unchanged.
- pc_load in F_REQ with no ack this cycle:
  - The request is already outstanding and imem_addr must stay stable, so -> F_DROP and latch the target into fetch_addr_next.
  - In F_DROP, imem_req stays 1 with the old address. On ack the data is discarded, fetch_addr<=target, -> F_REQ.
- pc_load in F_REQ with imem_ack in the same cycle: data is discarded, fetch_addr<=target, -> F_REQ.
- pc_load while in F_DROP: overwrites the pending target and stays in F_DROP.
- Timeout:
  - to_cnt counts cycles in F_REQ/F_DROP and clears on ack or on leaving those states.
  - At all-ones: fetch_err<=1 and stays set. The handshake continues waiting.
  - fetch_err clears only on rst or pc_load.
- Address arithmetic is modulo 2^ADDR_W: fetch_addr and PC wrap from 0xFFFF_FFFC to 0x0000_0000.
- Reset mid-handshake: the request is dropped immediately, and any late ack after reset release is ignored because the state is F_IDLE.

Test Plan:
- Reset release, memory acks on the first req cycle with 0xE0810002 -> imem_req high cycle 2 at addr 0; W_IR_valid=1 cycle 3; write_ir pulse -> IR=0xE0810002, PC=4, next req addr=4.
- write_pc=1, write_ir=0 held for 5 cycles with buffer full -> IR, PC, buffer and imem_req all unchanged.
- pc_load with pc_new=0x103 while in F_REQ, ack 2 cycles later -> first ack data discarded, imem_addr holds the old value until that ack, then req at 0x100; IR later loads the 0x100 word with PC=0x104.
- pc_load coincident with write_ir in F_FULL -> IR unchanged, W_IR_valid=0 next cycle, next req at new target.
- No ack for 255 cycles -> fetch_err=1 on cycle 255 and held; a later ack still fills the buffer; pc_load clears fetch_err.
- RESET_PC=0xFFFF_FFFC, one fetch consumed -> PC=0, next imem_addr=0; async rst asserted mid-F_REQ -> imem_req=0 immediately.
